// File: rtl/sram_port_sequencer.sv
// Request sequencer for a single-port synchronous SRAM: issues requests, captures read data one
// cycle after issue and returns in-order responses through a credit-limited response FIFO.
module sram_port_sequencer #(
   parameter int unsigned ADDR_BITS  = 9,
   parameter int unsigned DATA_BITS  = 256,
   parameter int unsigned MASK_BITS  = 32,
   parameter int unsigned RESP_DEPTH = 2
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_write,
   input  logic [ADDR_BITS-1:0]             req_addr,
   input  logic [DATA_BITS-1:0]             req_wdata,
   input  logic [MASK_BITS-1:0]             req_wmask,
   output logic                             resp_valid,
   input  logic                             resp_ready,
   output logic                             resp_write,
   output logic [DATA_BITS-1:0]             resp_rdata,
   output logic                             sram_en,
   output logic                             sram_wmode,
   output logic [ADDR_BITS-1:0]             sram_addr,
   output logic [MASK_BITS-1:0]             sram_wmask,
   output logic [DATA_BITS-1:0]             sram_wdata,
   input  logic [DATA_BITS-1:0]             sram_rdata,
   output logic [$clog2(RESP_DEPTH+1)-1:0]  occupancy
);

   localparam int unsigned OccBits = $clog2(RESP_DEPTH + 1);
   localparam int unsigned PtrBits = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

   logic                 inflight_valid_q, inflight_write_q;
   logic [PtrBits-1:0]   rd_ptr_q, wr_ptr_q;
   logic [OccBits-1:0]   count_q, count_d;
   logic                 fifo_write_q [RESP_DEPTH];
   logic [DATA_BITS-1:0] fifo_data_q  [RESP_DEPTH];

   logic                 accept, fifo_empty, push, pop;
   logic                 bypass_write;
   logic [DATA_BITS-1:0] bypass_data;
   logic [OccBits-1:0]   reserved;

   function automatic logic [PtrBits-1:0] ptr_inc(input logic [PtrBits-1:0] p);
      return (p == PtrBits'(RESP_DEPTH - 1)) ? '0 : p + PtrBits'(1);
   endfunction

   always_comb begin
      reserved   = count_q + OccBits'(inflight_valid_q);
      occupancy  = reserved;
      // A slot freed by a dequeue only becomes visible next cycle.
      req_ready  = !reset && (reserved < OccBits'(RESP_DEPTH));
      accept     = req_valid && req_ready;

      sram_en    = accept;
      sram_wmode = req_write;
      sram_addr  = req_addr;
      sram_wdata = req_wdata;
      sram_wmask = req_write ? req_wmask : '0;
   end

   always_comb begin
      bypass_write = inflight_write_q;
      bypass_data  = inflight_write_q ? '0 : sram_rdata;
      fifo_empty   = (count_q == '0);
      resp_valid   = !reset && (inflight_valid_q || !fifo_empty);
      if (fifo_empty) begin
         resp_write = bypass_write;
         resp_rdata = bypass_data;
      end else begin
         resp_write = fifo_write_q[rd_ptr_q];
         resp_rdata = fifo_data_q[rd_ptr_q];
      end
      pop  = !reset && !fifo_empty && resp_ready;
      // SRAM read data is only held until the next access, so an untaken bypass must be captured.
      push = !reset && inflight_valid_q && !(fifo_empty && resp_ready);

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + OccBits'(1);
      end else if (pop && !push) begin
         count_d = count_q - OccBits'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         inflight_valid_q <= 1'b0;
         inflight_write_q <= 1'b0;
         rd_ptr_q         <= '0;
         wr_ptr_q         <= '0;
         count_q          <= '0;
      end else begin
         inflight_valid_q <= accept;
         if (accept) begin
            inflight_write_q <= req_write;
         end
         if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_write_q[wr_ptr_q] <= bypass_write;
         fifo_data_q[wr_ptr_q]  <= bypass_data;
      end
   end

   no_overflow_a : assert property (@(posedge clock) disable iff (reset)
      !(push && !pop && count_q == OccBits'(RESP_DEPTH)));

endmodule

// File: tb/tb_sram_port_sequencer.sv
// Scoreboard bench for sram_port_sequencer with a behavioural byte-masked SRAM whose read data is
// only held until the next access.
module tb_sram_port_sequencer;

   localparam int unsigned ADDR_BITS  = 9;
   localparam int unsigned DATA_BITS  = 256;
   localparam int unsigned MASK_BITS  = 32;
   localparam int unsigned RESP_DEPTH = 2;
   localparam int unsigned OccBits    = $clog2(RESP_DEPTH + 1);
   localparam int unsigned Lane       = DATA_BITS / MASK_BITS;

   typedef logic [DATA_BITS-1:0] data_t;
   typedef struct {
      logic  write;
      data_t data;
      int    cyc;   // required sample cycle, or -1 for any
   } exp_t;

   localparam data_t Garbage = {8{32'hDEAD_BEEF}};

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 req_valid, req_ready, req_write;
   logic [ADDR_BITS-1:0] req_addr;
   data_t                req_wdata;
   logic [MASK_BITS-1:0] req_wmask;
   logic                 resp_valid, resp_ready, resp_write;
   data_t                resp_rdata;
   logic                 sram_en, sram_wmode;
   logic [ADDR_BITS-1:0] sram_addr;
   logic [MASK_BITS-1:0] sram_wmask;
   data_t                sram_wdata, sram_rdata;
   logic [OccBits-1:0]   occupancy;

   exp_t  sb_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   bit    done5    = 1'b0;
   data_t sram_mem [1 << ADDR_BITS];
   data_t ref_mem  [1 << ADDR_BITS];

   sram_port_sequencer #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .MASK_BITS (MASK_BITS),
      .RESP_DEPTH(RESP_DEPTH)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_write(resp_write),
      .resp_rdata(resp_rdata),
      .sram_en   (sram_en),
      .sram_wmode(sram_wmode),
      .sram_addr (sram_addr),
      .sram_wmask(sram_wmask),
      .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata),
      .occupancy (occupancy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      if (sram_en) begin
         if (sram_wmode) begin
            for (int i = 0; i < MASK_BITS; i++) begin
               if (sram_wmask[i]) sram_mem[sram_addr][Lane*i +: Lane] <= sram_wdata[Lane*i +: Lane];
            end
            sram_rdata <= Garbage;
         end else begin
            sram_rdata <= sram_mem[sram_addr];
         end
      end
   end

   function automatic void chk(input string name, input data_t act, input data_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic data_t rand_data();
      data_t d;
      for (int i = 0; i < DATA_BITS / 32; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   function automatic void push_exp(input logic w, input data_t d, input int c);
      exp_t e;
      e.write = w;
      e.data  = d;
      e.cyc   = c;
      sb_q.push_back(e);
   endfunction

   // Monitor: pops the scoreboard on every response handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && sram_en && !sram_wmode) chk("read_wmask_zero", data_t'(sram_wmask), '0);
         if (resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_resp", data_t'(1), data_t'(0));
            end else begin
               e = sb_q.pop_front();
               chk("resp_write", data_t'(resp_write), data_t'(e.write));
               chk("resp_rdata", resp_rdata, e.data);
               if (e.cyc >= 0) chk("resp_latency", data_t'(cyc), data_t'(e.cyc));
            end
         end
      end
   end

   // Holds one request until accepted; hand=1 uses hd as the expected read data.
   task automatic issue(input logic w, input logic [ADDR_BITS-1:0] a, input data_t d,
                        input logic [MASK_BITS-1:0] m, input bit hand, input data_t hd,
                        input int lat, output int waited);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_wmask = m;
      waited    = 0;
      @(negedge clock);
      while (!req_ready && waited < 50) begin
         waited++;
         @(negedge clock);
      end
      if (!req_ready) begin
         chk("issue_timeout", data_t'(0), data_t'(1));
      end else begin
         if (w) begin
            for (int i = 0; i < MASK_BITS; i++) begin
               if (m[i]) ref_mem[a][Lane*i +: Lane] = d[Lane*i +: Lane];
            end
            push_exp(1'b1, '0, (lat >= 0) ? cyc + lat : -1);
         end else begin
            push_exp(1'b0, hand ? hd : ref_mem[a], (lat >= 0) ? cyc + lat : -1);
         end
      end
      @(posedge clock);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk("drain_empty", data_t'(sb_q.size()), '0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      int w, stalls;
      req_valid  = 1'b1;   // must be ignored during reset
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_wmask  = '0;
      resp_ready = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_req_ready", data_t'(req_ready), '0);
      chk("rst_resp_valid", data_t'(resp_valid), '0);
      chk("rst_sram_en", data_t'(sram_en), '0);
      chk("rst_occupancy", data_t'(occupancy), '0);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      reset     = 1'b0;
      @(negedge clock);
      chk("post_rst_ready", data_t'(req_ready), data_t'(1));

      // 1: write then read-back, back-to-back, latency 1 each
      @(posedge clock);
      #1;
      resp_ready = 1'b1;
      issue(1'b1, 9'h005, {32{8'hA5}}, '1, 1'b0, '0, 1, w);
      chk("t1_wr_nostall", data_t'(w), '0);
      issue(1'b0, 9'h005, '0, '1, 1'b1, {32{8'hA5}}, 1, w);
      chk("t1_rd_nostall", data_t'(w), '0);
      drain();

      // 2: byte lane mask
      issue(1'b1, 9'h010, '0, '1, 1'b0, '0, 1, w);
      issue(1'b1, 9'h010, '1, 32'h0000_0001, 1'b0, '0, 1, w);
      issue(1'b0, 9'h010, '0, '0, 1'b1, {{31{8'h00}}, 8'hFF}, 1, w);
      drain();

      // 3: backpressure fills both slots, credit returns the cycle after the first pop
      issue(1'b1, 9'h001, {32{8'h11}}, '1, 1'b0, '0, -1, w);
      issue(1'b1, 9'h002, {32{8'h22}}, '1, 1'b0, '0, -1, w);
      issue(1'b1, 9'h003, {32{8'h33}}, '1, 1'b0, '0, -1, w);
      drain();
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_wmask  = '1;
      req_addr   = 9'h001;
      @(negedge clock);
      chk("t3_ready_1", data_t'(req_ready), data_t'(1));
      push_exp(1'b0, {32{8'h11}}, -1);
      @(posedge clock);
      #1;
      req_addr = 9'h002;
      @(negedge clock);
      chk("t3_ready_2", data_t'(req_ready), data_t'(1));
      push_exp(1'b0, {32{8'h22}}, -1);
      @(posedge clock);
      #1;
      req_addr = 9'h003;
      @(negedge clock);
      chk("t3_full_ready", data_t'(req_ready), '0);
      chk("t3_full_occ", data_t'(occupancy), data_t'(2));
      @(posedge clock);
      @(negedge clock);
      chk("t3_hold_ready", data_t'(req_ready), '0);
      chk("t3_hold_occ", data_t'(occupancy), data_t'(2));
      @(posedge clock);
      #1;
      resp_ready = 1'b1;
      @(negedge clock);
      chk("t3_no_same_cycle_credit", data_t'(req_ready), '0);
      @(posedge clock);
      @(negedge clock);
      chk("t3_credit_back", data_t'(req_ready), data_t'(1));
      push_exp(1'b0, {32{8'h33}}, -1);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      drain();

      // 4: streaming with resp_ready held high, no stalls, latency 1
      for (int a = 0; a < 16; a++) issue(1'b1, 9'(a), rand_data(), '1, 1'b0, '0, 1, w);
      stalls = 0;
      for (int i = 0; i < 100; i++) begin
         issue(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), rand_data(), $urandom,
               1'b0, '0, 1, w);
         stalls += w;
      end
      chk("t4_no_stalls", data_t'(stalls), '0);
      drain();

      // 5: random response backpressure over a few hot addresses
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               issue(1'($urandom_range(0, 1)), 9'($urandom_range(0, 3)), rand_data(), $urandom,
                     1'b0, '0, -1, w);
            end
            done5 = 1'b1;
         end
         begin
            while (!done5) begin
               @(posedge clock);
               #1;
               resp_ready = 1'($urandom_range(0, 1));
               @(negedge clock);
               chk("t5_occ_bound", data_t'(occupancy <= OccBits'(RESP_DEPTH)), data_t'(1));
            end
         end
      join
      resp_ready = 1'b1;
      drain();

      // 6: reset with two buffered responses discards them
      issue(1'b1, 9'h100, {32{8'h5A}}, '1, 1'b0, '0, -1, w);
      drain();
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_addr   = 9'h100;
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      @(negedge clock);
      chk("t6_pre_occ", data_t'(occupancy), data_t'(2));
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("t6_rst_resp_valid", data_t'(resp_valid), '0);
      chk("t6_rst_occ", data_t'(occupancy), '0);
      chk("t6_rst_ready", data_t'(req_ready), '0);
      chk("t6_rst_sram_en", data_t'(sram_en), '0);
      @(posedge clock);
      #1;
      reset      = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      issue(1'b1, 9'h101, {32{8'h3C}}, '1, 1'b0, '0, 1, w);
      issue(1'b0, 9'h101, '0, '0, 1'b1, {32{8'h3C}}, 1, w);
      drain();
      repeat (3) @(posedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
